// File: rtl/rpc_cmd_splitter_if.sv
// Handshake bundle between the AXI front end, the splitter and the RPC command FSM.
// The slave view belongs to the splitter; the master view belongs to its environment.
interface rpc_cmd_splitter_if #(
   parameter int WordsWidth = 16
);
   logic                  txn_valid_i;
   logic                  txn_ready_o;
   logic                  txn_write_i;
   logic [19:0]           txn_addr_i;
   logic [WordsWidth-1:0] txn_words_i;
   logic                  cmd_valid_o;
   logic                  cmd_ready_i;
   logic                  cmd_write_o;
   logic [5:0]            cmd_len_o;
   logic [19:0]           cmd_addr_o;
   logic                  cmd_last_o;
   logic                  busy_o;

   modport slave (
      input  txn_valid_i, txn_write_i, txn_addr_i, txn_words_i, cmd_ready_i,
      output txn_ready_o, cmd_valid_o, cmd_write_o, cmd_len_o, cmd_addr_o,
             cmd_last_o, busy_o
   );

   modport master (
      output txn_valid_i, txn_write_i, txn_addr_i, txn_words_i, cmd_ready_i,
      input  txn_ready_o, cmd_valid_o, cmd_write_o, cmd_len_o, cmd_addr_o,
             cmd_last_o, busy_o
   );
endinterface

// File: rtl/rpc_cmd_splitter.sv
// Splits one linear DRAM transaction into commands of at most MaxBurst words
// that never cross a 2**ColWidth-word row; feeds the RPC command FSM.
module rpc_cmd_splitter #(
   parameter int MaxBurst   = 32,
   parameter int ColWidth   = 6,
   parameter int WordsWidth = 16
) (
   input logic               clk_i,
   input logic               rst_i,
   rpc_cmd_splitter_if.slave bus
);

   localparam int RowBits = ColWidth + 1;
   localparam int LW = (WordsWidth > 7)
                       ? ((WordsWidth > RowBits) ? WordsWidth : RowBits)
                       : ((7 > RowBits) ? 7 : RowBits);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] SPLIT = 2'd1;
   localparam logic [1:0] GAP   = 2'd2;

   localparam logic [RowBits-1:0] RowWords = RowBits'(1) << ColWidth;

   logic [1:0]            state;
   logic [19:0]           cur_addr;
   logic [WordsWidth-1:0] remaining;
   logic                  is_write;

   logic [RowBits-1:0] row_left;
   logic [LW-1:0]      rem_ext;
   logic [LW-1:0]      row_ext;
   logic [LW-1:0]      burst_ext;
   logic [LW-1:0]      min_rb;
   logic [LW-1:0]      len_ext;
   logic [5:0]         cur_len;
   logic               cur_last;
   logic               in_split;

   assign row_left  = RowWords - {1'b0, cur_addr[ColWidth-1:0]};
   assign rem_ext   = LW'(remaining);
   assign row_ext   = LW'(row_left);
   assign burst_ext = LW'(MaxBurst);
   assign min_rb    = (rem_ext < burst_ext) ? rem_ext : burst_ext;
   assign len_ext   = (min_rb < row_ext) ? min_rb : row_ext;
   assign cur_len   = len_ext[5:0];
   assign cur_last  = (rem_ext == len_ext);
   assign in_split  = (state == SPLIT);

   // Command fields come only from registered state, so nothing here is
   // combinationally dependent on cmd_ready_i or the txn_* inputs.
   assign bus.txn_ready_o = (state == IDLE);
   assign bus.cmd_valid_o = in_split;
   assign bus.busy_o      = in_split;
   assign bus.cmd_write_o = in_split & is_write;
   assign bus.cmd_len_o   = in_split ? cur_len  : 6'd0;
   assign bus.cmd_addr_o  = in_split ? cur_addr : 20'd0;
   assign bus.cmd_last_o  = in_split & cur_last;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values of the others, independent of statement order.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state     <= IDLE;
         cur_addr  <= '0;
         remaining <= '0;
         is_write  <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               // A zero-word transaction is consumed without issuing anything.
               if (bus.txn_valid_i && (bus.txn_words_i != '0)) begin
                  cur_addr  <= bus.txn_addr_i;
                  remaining <= bus.txn_words_i;
                  is_write  <= bus.txn_write_i;
                  state     <= SPLIT;
               end
            end
            SPLIT: begin
               if (bus.cmd_ready_i) begin
                  cur_addr  <= cur_addr + 20'(cur_len);
                  remaining <= remaining - len_ext[WordsWidth-1:0];
                  if (cur_last) state <= GAP;
               end
            end
            GAP:     state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule
